// File: rtl/best_result_reporter.sv
// Serializes each best-result improvement from the search core into a framed byte stream
// (sync, bits-off, nonce, checksum) with a one-deep pending slot for results that arrive mid-frame.
module best_result_reporter #(
  parameter int unsigned NONCE_W   = 256,
  parameter int unsigned BITS_W    = 10,
  parameter int unsigned THRESHOLD = 1023,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [NONCE_W-1:0] best_nonce_i,
  input  logic [BITS_W-1:0]  best_bits_off_i,
  output logic [7:0]         byte_o,
  output logic               byte_valid_o,
  input  logic               byte_ready_i,
  output logic               busy_o,
  output logic [7:0]         overflow_count_o
);

  localparam int unsigned NB = NONCE_W / 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {StIdle, StSync, StBitsHi, StBitsLo, StNonce, StCsum} state_e;

  state_e             state_q;
  logic [NONCE_W-1:0] act_nonce_q, pend_nonce_q;
  logic [BITS_W-1:0]  act_bits_q, pend_bits_q, last_bits_q;
  logic               pend_valid_q;
  logic [IW-1:0]      idx_q;
  logic [7:0]         csum_q, byte_q, ovf_q;
  logic               valid_q;

  logic               trigger, fire, csum_hs;
  logic [15:0]        bits16;
  logic [NONCE_W-1:0] nonce_sh;

  always_comb begin
    trigger  = enable_i && (best_bits_off_i != last_bits_q) &&
               (32'(best_bits_off_i) < THRESHOLD);
    fire     = valid_q && byte_ready_i;
    csum_hs  = (state_q == StCsum) && fire;
    bits16   = 16'(act_bits_q);
    nonce_sh = act_nonce_q << 8;
  end

  assign byte_o           = byte_q;
  assign byte_valid_o     = valid_q;
  assign busy_o           = (state_q != StIdle) || pend_valid_q;
  assign overflow_count_o = ovf_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      act_nonce_q  <= '0;
      act_bits_q   <= '0;
      pend_nonce_q <= '0;
      pend_bits_q  <= '0;
      pend_valid_q <= 1'b0;
      last_bits_q  <= '1;
      idx_q        <= '0;
      csum_q       <= 8'h00;
      byte_q       <= 8'h00;
      valid_q      <= 1'b0;
      ovf_q        <= 8'h00;
    end else begin
      last_bits_q <= best_bits_off_i;

      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            act_nonce_q <= best_nonce_i;
            act_bits_q  <= best_bits_off_i;
            state_q     <= StSync;
            byte_q      <= SYNC_BYTE;
            valid_q     <= 1'b1;
            csum_q      <= 8'h00;
          end
        end
        StSync: begin
          if (fire) begin
            state_q <= StBitsHi;
            byte_q  <= bits16[15:8];
            csum_q  <= csum_q ^ bits16[15:8];
          end
        end
        StBitsHi: begin
          if (fire) begin
            state_q <= StBitsLo;
            byte_q  <= bits16[7:0];
            csum_q  <= csum_q ^ bits16[7:0];
          end
        end
        StBitsLo: begin
          if (fire) begin
            state_q <= StNonce;
            idx_q   <= IW'(NB - 1);
            byte_q  <= act_nonce_q[NONCE_W-1 -: 8];
            csum_q  <= csum_q ^ act_nonce_q[NONCE_W-1 -: 8];
          end
        end
        StNonce: begin
          if (fire) begin
            if (idx_q == '0) begin
              // csum_q already folds in the last nonce byte
              state_q <= StCsum;
              byte_q  <= csum_q;
            end else begin
              idx_q       <= idx_q - IW'(1);
              act_nonce_q <= nonce_sh;
              byte_q      <= nonce_sh[NONCE_W-1 -: 8];
              csum_q      <= csum_q ^ nonce_sh[NONCE_W-1 -: 8];
            end
          end
        end
        StCsum: begin
          if (fire) begin
            if (pend_valid_q || trigger) begin
              act_nonce_q <= pend_valid_q ? pend_nonce_q : best_nonce_i;
              act_bits_q  <= pend_valid_q ? pend_bits_q : best_bits_off_i;
              state_q     <= StSync;
              byte_q      <= SYNC_BYTE;
              csum_q      <= 8'h00;
            end else begin
              state_q <= StIdle;
              byte_q  <= 8'h00;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase

      // A trigger at the final handshake with an empty slot goes straight to the active buffer
      if ((state_q != StIdle) && trigger && !(csum_hs && !pend_valid_q)) begin
        pend_nonce_q <= best_nonce_i;
        pend_bits_q  <= best_bits_off_i;
        pend_valid_q <= 1'b1;
        if (pend_valid_q && !csum_hs && (ovf_q != 8'hFF)) begin
          ovf_q <= ovf_q + 8'd1;
        end
      end else if (csum_hs) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_best_result_reporter.sv
// Directed bench for best_result_reporter: frame contents, latency, back-pressure, pending
// overflow, threshold, enable and mid-frame reset.
module tb_best_result_reporter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [255:0] nonce;
  logic [9:0]   bits;
  logic         ready;
  logic [7:0]   b1, b2, ovf1, ovf2;
  logic         v1, v2, busy1, busy2;

  bit           sel2 = 1'b0;
  logic         obs_v;
  logic [7:0]   obs_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] fr     [36];
  logic [7:0] exp_fr [36];
  bit         ok;
  int         cnt;

  always #5 clk = ~clk;

  assign obs_v = sel2 ? v2 : v1;
  assign obs_b = sel2 ? b2 : b1;

  best_result_reporter u_dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .enable_i         (en),
    .best_nonce_i     (nonce),
    .best_bits_off_i  (bits),
    .byte_o           (b1),
    .byte_valid_o     (v1),
    .byte_ready_i     (ready),
    .busy_o           (busy1),
    .overflow_count_o (ovf1)
  );

  best_result_reporter #(.THRESHOLD(512)) u_dut_thr (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .enable_i         (en),
    .best_nonce_i     (nonce),
    .best_bits_off_i  (bits),
    .byte_o           (b2),
    .byte_valid_o     (v2),
    .byte_ready_i     (ready),
    .busy_o           (busy2),
    .overflow_count_o (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] make_nonce(input logic [7:0] base);
    logic [255:0] n;
    for (int i = 0; i < 32; i++) n[255 - 8*i -: 8] = base + 8'(i);
    return n;
  endfunction

  function automatic void build_exp(input logic [9:0] bo, input logic [255:0] n);
    logic [15:0] b16;
    logic [7:0]  x;
    b16       = {6'b0, bo};
    exp_fr[0] = 8'hA5;
    exp_fr[1] = b16[15:8];
    exp_fr[2] = b16[7:0];
    for (int i = 0; i < 32; i++) exp_fr[3 + i] = n[255 - 8*i -: 8];
    x = 8'h00;
    for (int i = 1; i < 35; i++) x = x ^ exp_fr[i];
    exp_fr[35] = x;
  endfunction

  task automatic get_frame(input int stall_at, input int stall_len, output bit got_all);
    int t;
    got_all = 1'b0;
    t = 0;
    while (!obs_v && t < 64) begin
      tick();
      t++;
    end
    for (int i = 0; i < 36; i++) begin
      if (!obs_v) return;
      if (i == stall_at) begin
        ready = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          tick();
          check("stall_valid", 32'(obs_v), 32'd1);
          check("stall_byte", 32'(obs_b), 32'(exp_fr[i]));
        end
        ready = 1'b1;
      end
      fr[i] = obs_b;
      tick();
    end
    got_all = 1'b1;
  endtask

  task automatic compare_frame(input string tag);
    for (int i = 0; i < 36; i++) check($sformatf("%s[%0d]", tag, i), 32'(fr[i]), 32'(exp_fr[i]));
  endtask

  task automatic count_valid(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (obs_v) c++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    bits  = 10'h3FF;
    nonce = '0;
    ready = 1'b1;
    #12;
    check("rst_valid", 32'(v1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle with bits-off at all ones
    count_valid(100, cnt);
    check("t1_valid_cycles", 32'(cnt), 32'd0);
    check("t1_busy", 32'(busy1), 32'd0);
    check("t1_ovf", 32'(ovf1), 32'd0);

    // 2: plain frame, one-cycle latency
    bits  = 10'd300;
    nonce = make_nonce(8'h01);
    build_exp(10'd300, make_nonce(8'h01));
    tick();
    check("t2_latency", 32'(v1), 32'd1);
    get_frame(-1, 0, ok);
    check("t2_complete", 32'(ok), 32'd1);
    check("t2_sync", 32'(fr[0]), 32'hA5);
    check("t2_bits_hi", 32'(fr[1]), 32'h01);
    check("t2_bits_lo", 32'(fr[2]), 32'h2C);
    check("t2_csum", 32'(fr[35]), 32'h0D);
    compare_frame("t2_byte");
    check("t2_idle_valid", 32'(v1), 32'd0);
    check("t2_idle_busy", 32'(busy1), 32'd0);

    // 3: back-pressure on nonce byte 01
    bits = 10'h3FF;
    tick();
    tick();
    bits = 10'd300;
    get_frame(3, 5, ok);
    check("t3_complete", 32'(ok), 32'd1);
    check("t3_held_byte", 32'(exp_fr[3]), 32'h01);
    compare_frame("t3_byte");

    // 4: three improvements mid-frame -> two overwrites, back-to-back frames
    bits = 10'h3FF;
    tick();
    tick();
    bits  = 10'd300;
    nonce = make_nonce(8'h10);
    tick();
    check("t4_latency", 32'(v1), 32'd1);
    build_exp(10'd300, make_nonce(8'h10));
    fork
      get_frame(-1, 0, ok);
      begin
        tick();
        tick();
        bits = 10'd200; nonce = make_nonce(8'h40); tick();
        bits = 10'd150; nonce = make_nonce(8'h60); tick();
        bits = 10'd100; nonce = make_nonce(8'h80); tick();
      end
    join
    check("t4_first_complete", 32'(ok), 32'd1);
    compare_frame("t4_f1");
    check("t4_back_to_back", 32'(v1), 32'd1);
    check("t4_ovf", 32'(ovf1), 32'd2);
    build_exp(10'd100, make_nonce(8'h80));
    get_frame(-1, 0, ok);
    check("t4_second_complete", 32'(ok), 32'd1);
    compare_frame("t4_f2");
    check("t4_busy_after", 32'(busy1), 32'd0);
    check("t4_valid_after", 32'(v1), 32'd0);

    // enable low: value seen while disabled is never reported
    en   = 1'b0;
    bits = 10'd250;
    count_valid(10, cnt);
    check("en_off_frames", 32'(cnt), 32'd0);
    en = 1'b1;
    count_valid(10, cnt);
    check("en_on_stale", 32'(cnt), 32'd0);
    check("en_busy", 32'(busy1), 32'd0);

    // 6: reset mid-frame
    bits = 10'h3FF;
    tick();
    tick();
    bits  = 10'd300;
    nonce = make_nonce(8'h01);
    tick();
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(v1), 32'd0);
    check("t6_async_busy", 32'(busy1), 32'd0);
    check("t6_async_ovf", 32'(ovf1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_restart", 32'(v1), 32'd1);
    build_exp(10'd300, make_nonce(8'h01));
    get_frame(-1, 0, ok);
    check("t6_complete", 32'(ok), 32'd1);
    compare_frame("t6_byte");
    rst_n = 1'b0;
    bits  = 10'h3FF;
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(20, cnt);
    check("t6_all_ones_quiet", 32'(cnt), 32'd0);

    // 5: THRESHOLD = 512 instance
    sel2 = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bits  = 10'd600;
    nonce = make_nonce(8'hC0);
    count_valid(20, cnt);
    check("t5_above_thr", 32'(cnt), 32'd0);
    bits  = 10'd400;
    nonce = make_nonce(8'h21);
    build_exp(10'd400, make_nonce(8'h21));
    get_frame(-1, 0, ok);
    check("t5_complete", 32'(ok), 32'd1);
    check("t5_bits_hi", 32'(fr[1]), 32'h01);
    check("t5_bits_lo", 32'(fr[2]), 32'h90);
    compare_frame("t5_byte");
    check("t5_busy_after", 32'(busy2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
